bit_counter_param: RTL

Parametrised population-count unit: captures a WIDTH-bit word on a start handshake, then counts the ones or the zeros one bit per cycle, LSB first, with an integrated controller. Shifting stops early once no counted bits remain. The result is presented with a held done flag until the requester drops start. This is the next-generation replacement for the fixed 8-bit / 4-bit-result bit-counter datapath and controller pair in the lab designs.

---
 rtl/bit_counter_param.sv | 86 ++++++++
 1 files changed

// File: rtl/bit_counter_param.sv
// Parametrised population counter: captures a WIDTH-bit word on start, then
// counts ones (or zeros) LSB first, stopping early once no counted bits remain.
module bit_counter_param #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic             count_zeros,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Zeros mode inverts once at capture, so the shift loop only ever counts ones.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sr_d    = count_zeros ? ~A : A;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (~|sr_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(sr_q[0]);
                    sr_d  = sr_q >> 1;
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        result = '0;
        unique case (state_q)
            S_IDLE:  ready = 1'b1;
            S_SHIFT: busy  = 1'b1;
            S_DONE: begin
                done   = 1'b1;
                result = cnt_q;
            end
            default: ;
        endcase
    end

endmodule
